// File: rtl/cap_vramctrl.sv
// -----------------------------------------------------------------------------
// cap_vramctrl
//   Write-side VRAM controller for the capture path. Pops 64-bit pixel pairs
//   from a first-word-fall-through FIFO and writes them to the frame buffer as
//   fixed-length INCR AXI bursts. Only one burst is in flight at a time. A
//   frame is the whole picture for the latched resolution. FRAME_DONE pulses
//   once when the last burst of the frame has been acknowledged.
//
//   The parent ties the constant AXI fields as follows:
//     AWLEN = BURST_LEN-1, AWSIZE = 3, AWBURST = INCR, WSTRB = 8'hFF.
//   The parent also forces AWADDR[31:29] to 3'b001.
//
// Ports
//   ACLK, ARESETN       clock; asynchronous active-low reset
//   START               one-cycle pulse that starts a frame (only taken in IDLE)
//   STOP                level; ends the frame after the current burst
//   BASEADDR            frame base address; bits [6:0] are treated as zero
//   RESOL               00/11 = 640x480, 01 = 800x600, 10 = 1024x768
//   FIFO_DOUT           FIFO head word (low pixel in [31:0])
//   FIFO_RDCNT          number of words available in the FIFO
//   FIFO_RD             pops the FIFO head on each W handshake
//   VRAMCTRL_AWADDR     start address of the current burst
//   M_AXI_AW*/W*/B*     AXI write channels
//   BUSY                high whenever the FSM is not in IDLE
//   FRAME_DONE          one-cycle pulse after the last burst of a frame
//   BRESP_ERR           sticky; set by any non-OKAY response in the frame
// -----------------------------------------------------------------------------
module cap_vramctrl #(
   parameter int BURST_LEN = 16,
   parameter int CNT_WIDTH = 10
) (
   input  logic                 ACLK,
   input  logic                 ARESETN,
   input  logic                 START,
   input  logic                 STOP,
   input  logic [31:0]          BASEADDR,
   input  logic [1:0]           RESOL,
   input  logic [63:0]          FIFO_DOUT,
   input  logic [CNT_WIDTH-1:0] FIFO_RDCNT,
   output logic                 FIFO_RD,
   output logic [31:0]          VRAMCTRL_AWADDR,
   output logic                 M_AXI_AWVALID,
   input  logic                 M_AXI_AWREADY,
   output logic [63:0]          M_AXI_WDATA,
   output logic                 M_AXI_WLAST,
   output logic                 M_AXI_WVALID,
   input  logic                 M_AXI_WREADY,
   input  logic [1:0]           M_AXI_BRESP,
   input  logic                 M_AXI_BVALID,
   output logic                 M_AXI_BREADY,
   output logic                 BUSY,
   output logic                 FRAME_DONE,
   output logic                 BRESP_ERR
);

   // Number of bursts in a frame: each burst carries 2*BURST_LEN pixels.
   localparam int             PIX_640  = 640 * 480;
   localparam int             PIX_800  = 800 * 600;
   localparam int             PIX_1024 = 1024 * 768;
   localparam logic [15:0]    TOT_640  = 16'(PIX_640  / (2 * BURST_LEN));
   localparam logic [15:0]    TOT_800  = 16'(PIX_800  / (2 * BURST_LEN));
   localparam logic [15:0]    TOT_1024 = 16'(PIX_1024 / (2 * BURST_LEN));

   localparam int             BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [31:0]    ADDR_INC  = 32'(BURST_LEN * 8);
   localparam logic [CNT_WIDTH:0] BURST_WORDS = (CNT_WIDTH + 1)'(BURST_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ADDR,
      S_DATA,
      S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         addr_q, addr_d;
   logic [1:0]          resol_q, resol_d;
   logic [15:0]         burst_q, burst_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                err_q, err_d;
   logic                done_q, done_d;
   logic                awvalid_q, wvalid_q, bready_q, busy_q;

   logic [15:0]         total_bursts;
   logic                last_burst;
   logic                fifo_ready;
   logic                w_hs;

   // RESOL 11 falls back to 640x480.
   always_comb begin
      case (resol_q)
         2'b01:   total_bursts = TOT_800;
         2'b10:   total_bursts = TOT_1024;
         default: total_bursts = TOT_640;
      endcase
   end

   assign last_burst = (burst_q == total_bursts - 16'd1);

   // A burst only starts with a full burst already queued, so the W phase can
   // never pop an empty FIFO.
   assign fifo_ready = ({1'b0, FIFO_RDCNT} >= BURST_WORDS);

   // wvalid_q is only ever high in DATA.
   assign w_hs = wvalid_q & M_AXI_WREADY;

   // NOTE: every signal this block assigns gets its default first. A path that
   //       left one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      resol_d = resol_q;
      burst_d = burst_q;
      beat_d  = beat_q;
      err_d   = err_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               addr_d  = BASEADDR & 32'hFFFF_FF80;
               resol_d = RESOL;
               burst_d = '0;
               beat_d  = '0;
               err_d   = 1'b0;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (STOP) begin
               state_d = S_IDLE;
            end else if (fifo_ready) begin
               state_d = S_ADDR;
            end
         end

         S_ADDR: begin
            if (M_AXI_AWREADY) begin
               state_d = S_DATA;
            end
         end

         S_DATA: begin
            if (w_hs) begin
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = S_RESP;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end

         S_RESP: begin
            if (M_AXI_BVALID) begin
               if (M_AXI_BRESP != 2'b00) begin
                  err_d = 1'b1;
               end
               // Completing the frame takes priority over STOP.
               if (last_burst) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else if (STOP) begin
                  state_d = S_IDLE;
               end else begin
                  addr_d  = addr_q + ADDR_INC;  // wraps mod 2^32
                  burst_d = burst_q + 16'd1;
                  state_d = S_WAIT;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // The handshake outputs are decoded from the next state. This way they
   // come straight from flops yet still line up with the state register.
   // NOTE: sequential state uses non-blocking assignments only. Every flop
   //       then samples pre-edge values, whatever order the statements run in.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         resol_q   <= '0;
         burst_q   <= '0;
         beat_q    <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         resol_q   <= resol_d;
         burst_q   <= burst_d;
         beat_q    <= beat_d;
         err_q     <= err_d;
         done_q    <= done_d;
         awvalid_q <= (state_d == S_ADDR);
         wvalid_q  <= (state_d == S_DATA);
         bready_q  <= (state_d == S_RESP);
         busy_q    <= (state_d != S_IDLE);
      end
   end

   assign VRAMCTRL_AWADDR = addr_q;
   assign M_AXI_AWVALID   = awvalid_q;
   assign M_AXI_WVALID    = wvalid_q;
   assign M_AXI_WDATA     = FIFO_DOUT;
   assign M_AXI_WLAST     = wvalid_q & (beat_q == LAST_BEAT);
   assign FIFO_RD         = w_hs;
   assign M_AXI_BREADY    = bready_q;
   assign BUSY            = busy_q;
   assign FRAME_DONE      = done_q;
   assign BRESP_ERR       = err_q;

endmodule

// File: tb/tb_cap_vramctrl.sv
// -----------------------------------------------------------------------------
// tb_cap_vramctrl
//   Directed bench for cap_vramctrl with BURST_LEN=16. The bench holds a
//   counting FIFO model (word i = {(2i+1)^A5A50000, 2i}) and drives the AXI
//   slave side by hand. A full frame is far too long to simulate, so each
//   frame-end check first moves the burst counter and address close to the
//   end of the frame, then finishes the remaining bursts normally.
// -----------------------------------------------------------------------------
module tb_cap_vramctrl;

   localparam int CNT_WIDTH = 10;

   logic                 ACLK;
   logic                 ARESETN;
   logic                 START;
   logic                 STOP;
   logic [31:0]          BASEADDR;
   logic [1:0]           RESOL;
   logic [63:0]          FIFO_DOUT;
   logic [CNT_WIDTH-1:0] FIFO_RDCNT;
   logic                 FIFO_RD;
   logic [31:0]          VRAMCTRL_AWADDR;
   logic                 M_AXI_AWVALID;
   logic                 M_AXI_AWREADY;
   logic [63:0]          M_AXI_WDATA;
   logic                 M_AXI_WLAST;
   logic                 M_AXI_WVALID;
   logic                 M_AXI_WREADY;
   logic [1:0]           M_AXI_BRESP;
   logic                 M_AXI_BVALID;
   logic                 M_AXI_BREADY;
   logic                 BUSY;
   logic                 FRAME_DONE;
   logic                 BRESP_ERR;

   int n_cmp   = 0;
   int n_err   = 0;
   int pop_cnt = 0;   // FIFO model read pointer, advanced by FIFO_RD
   int exp_idx = 0;   // word index expected on the next W handshake

   logic [15:0] jump_burst;
   logic [31:0] jump_addr;

   cap_vramctrl #(.BURST_LEN(16), .CNT_WIDTH(CNT_WIDTH)) dut (
      .ACLK            (ACLK),
      .ARESETN         (ARESETN),
      .START           (START),
      .STOP            (STOP),
      .BASEADDR        (BASEADDR),
      .RESOL           (RESOL),
      .FIFO_DOUT       (FIFO_DOUT),
      .FIFO_RDCNT      (FIFO_RDCNT),
      .FIFO_RD         (FIFO_RD),
      .VRAMCTRL_AWADDR (VRAMCTRL_AWADDR),
      .M_AXI_AWVALID   (M_AXI_AWVALID),
      .M_AXI_AWREADY   (M_AXI_AWREADY),
      .M_AXI_WDATA     (M_AXI_WDATA),
      .M_AXI_WLAST     (M_AXI_WLAST),
      .M_AXI_WVALID    (M_AXI_WVALID),
      .M_AXI_WREADY    (M_AXI_WREADY),
      .M_AXI_BRESP     (M_AXI_BRESP),
      .M_AXI_BVALID    (M_AXI_BVALID),
      .M_AXI_BREADY    (M_AXI_BREADY),
      .BUSY            (BUSY),
      .FRAME_DONE      (FRAME_DONE),
      .BRESP_ERR       (BRESP_ERR)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   function automatic logic [63:0] data_of(input int i);
      return {32'(2 * i + 1) ^ 32'hA5A5_0000, 32'(2 * i)};
   endfunction

   assign FIFO_DOUT = data_of(pop_cnt);

   always @(posedge ACLK) begin
      if (FIFO_RD) pop_cnt <= pop_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_awvalid"}, 64'(M_AXI_AWVALID), 64'd0);
      check({tag, "_wvalid"},  64'(M_AXI_WVALID),  64'd0);
      check({tag, "_wlast"},   64'(M_AXI_WLAST),   64'd0);
      check({tag, "_fifo_rd"}, 64'(FIFO_RD),       64'd0);
      check({tag, "_bready"},  64'(M_AXI_BREADY),  64'd0);
      check({tag, "_busy"},    64'(BUSY),          64'd0);
      check({tag, "_done"},    64'(FRAME_DONE),    64'd0);
      check({tag, "_err"},     64'(BRESP_ERR),     64'd0);
      check({tag, "_awaddr"},  64'(VRAMCTRL_AWADDR), 64'd0);
   endtask

   task automatic pulse_start(input logic [31:0] base, input logic [1:0] res);
      BASEADDR = base;
      RESOL    = res;
      START    = 1'b1;
      @(negedge ACLK);
      START    = 1'b0;
   endtask

   // Called while the DUT sits in WAIT. It loads the burst counter and the
   // address for burst index idx, so the frame can be finished quickly.
   task automatic jump_to(input int idx, input logic [31:0] base);
      FIFO_RDCNT = '0;
      jump_burst = 16'(idx);
      jump_addr  = base + 32'(idx * 128);
      force dut.burst_q = jump_burst;
      force dut.addr_q  = jump_addr;
      @(negedge ACLK);
      release dut.burst_q;
      release dut.addr_q;
      FIFO_RDCNT = 10'd512;
   endtask

   // One complete burst as seen from the slave side. Entered with the DUT in
   // WAIT or ADDR; returns on the negedge after the B handshake.
   task automatic run_burst(input logic [31:0] exp_addr, input bit rnd,
                            input int stop_beat, input logic [1:0] bresp,
                            input bit exp_done);
      int t;
      int beat;
      int n;
      t = 0;
      while (!M_AXI_AWVALID && t < 300) begin
         @(negedge ACLK);
         t++;
      end
      check("aw_wait", 64'(M_AXI_AWVALID), 64'd1);
      check("awaddr", 64'(VRAMCTRL_AWADDR), 64'(exp_addr));
      check("wvalid_in_addr", 64'(M_AXI_WVALID), 64'd0);
      n = rnd ? int'($urandom_range(3, 0)) : 0;
      repeat (n) begin
         @(negedge ACLK);
         check("awvalid_hold", 64'(M_AXI_AWVALID), 64'd1);
         check("awaddr_hold", 64'(VRAMCTRL_AWADDR), 64'(exp_addr));
      end
      M_AXI_AWREADY = 1'b1;
      @(negedge ACLK);
      M_AXI_AWREADY = 1'b0;
      check("awvalid_drop", 64'(M_AXI_AWVALID), 64'd0);

      beat = 0;
      t    = 0;
      while (beat < 16 && t < 200) begin
         check("wvalid", 64'(M_AXI_WVALID), 64'd1);
         check("wlast", 64'(M_AXI_WLAST), 64'(beat == 15));
         check("wdata", M_AXI_WDATA, data_of(exp_idx));
         if (beat == stop_beat) STOP = 1'b1;
         M_AXI_WREADY = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
         #1;
         check("fifo_rd", 64'(FIFO_RD), 64'(M_AXI_WREADY));
         if (M_AXI_WREADY) begin
            beat++;
            exp_idx++;
         end
         @(negedge ACLK);
         t++;
      end
      M_AXI_WREADY = 1'b0;
      check("w_beats", 64'(beat), 64'd16);
      check("wvalid_after", 64'(M_AXI_WVALID), 64'd0);
      check("bready", 64'(M_AXI_BREADY), 64'd1);

      n = rnd ? int'($urandom_range(2, 0)) : 0;
      repeat (n) begin
         @(negedge ACLK);
         check("bready_hold", 64'(M_AXI_BREADY), 64'd1);
         check("done_early", 64'(FRAME_DONE), 64'd0);
      end
      M_AXI_BVALID = 1'b1;
      M_AXI_BRESP  = bresp;
      @(negedge ACLK);
      M_AXI_BVALID = 1'b0;
      M_AXI_BRESP  = 2'b00;
      check("frame_done", 64'(FRAME_DONE), 64'(exp_done));
      check("bready_drop", 64'(M_AXI_BREADY), 64'd0);
      check("busy_after", 64'(BUSY), 64'(!(exp_done || stop_beat >= 0)));
   endtask

   task automatic check_frame_end(input string tag);
      @(negedge ACLK);
      check({tag, "_done_pulse"}, 64'(FRAME_DONE), 64'd0);
      repeat (5) @(negedge ACLK);
      check({tag, "_busy"}, 64'(BUSY), 64'd0);
      check({tag, "_no_aw"}, 64'(M_AXI_AWVALID), 64'd0);
   endtask

   initial begin
      ARESETN       = 1'b0;
      START         = 1'b0;
      STOP          = 1'b0;
      BASEADDR      = '0;
      RESOL         = '0;
      FIFO_RDCNT    = '0;
      M_AXI_AWREADY = 1'b0;
      M_AXI_WREADY  = 1'b0;
      M_AXI_BRESP   = 2'b00;
      M_AXI_BVALID  = 1'b0;
      jump_burst    = '0;
      jump_addr     = '0;

      // Reset state.
      repeat (3) @(negedge ACLK);
      check_idle_outputs("reset");
      ARESETN = 1'b1;
      @(negedge ACLK);
      check_idle_outputs("post_reset");

      // FIFO gate: 15 words never start a burst; 16 starts one a cycle later.
      FIFO_RDCNT = 10'd15;
      pulse_start(32'h2000_0000, 2'b00);
      check("gate_busy", 64'(BUSY), 64'd1);
      repeat (100) begin
         @(negedge ACLK);
         check("gate_no_aw", 64'(M_AXI_AWVALID), 64'd0);
      end
      FIFO_RDCNT = 10'd16;
      @(negedge ACLK);
      check("gate_aw_next", 64'(M_AXI_AWVALID), 64'd1);

      // Frame at 640x480, always ready: 9600 bursts, last one at 0x2012_BF80.
      run_burst(32'h2000_0000, 1'b0, -1, 2'b00, 1'b0);
      FIFO_RDCNT = 10'd512;
      for (int i = 1; i < 4; i++) run_burst(32'h2000_0000 + 32'(i * 128), 1'b0, -1, 2'b00, 1'b0);
      jump_to(9597, 32'h2000_0000);
      run_burst(32'h2012_BE80, 1'b0, -1, 2'b00, 1'b0);
      run_burst(32'h2012_BF00, 1'b0, -1, 2'b00, 1'b0);
      run_burst(32'h2012_BF80, 1'b0, -1, 2'b00, 1'b1);
      check_frame_end("vga");

      // 800x600 with random stalls; a START while busy must change nothing.
      pulse_start(32'h2100_0040, 2'b01);
      pulse_start(32'h2800_0000, 2'b00);
      for (int i = 0; i < 3; i++) run_burst(32'h2100_0000 + 32'(i * 128), 1'b1, -1, 2'b00, 1'b0);
      jump_to(14998, 32'h2100_0000);
      run_burst(32'h2100_0000 + 32'(14998 * 128), 1'b1, -1, 2'b00, 1'b0);
      run_burst(32'h2100_0000 + 32'(14999 * 128), 1'b1, -1, 2'b00, 1'b1);
      check_frame_end("svga");

      // STOP during DATA of burst 3: the burst finishes, then IDLE, no done.
      pulse_start(32'h2200_0000, 2'b10);
      for (int i = 0; i < 3; i++) run_burst(32'h2200_0000 + 32'(i * 128), 1'b0, -1, 2'b00, 1'b0);
      run_burst(32'h2200_0180, 1'b0, 7, 2'b00, 1'b0);
      STOP = 1'b0;
      check_frame_end("stop");

      // STOP while waiting for FIFO data ends the frame at once.
      FIFO_RDCNT = '0;
      pulse_start(32'h2200_0000, 2'b10);
      STOP = 1'b1;
      @(negedge ACLK);
      check("stop_wait_busy", 64'(BUSY), 64'd0);
      STOP = 1'b0;
      FIFO_RDCNT = 10'd512;

      // SLVERR on burst 0 is sticky for the rest of the frame. STOP in the
      // last burst loses to frame completion.
      pulse_start(32'h2300_0000, 2'b10);
      run_burst(32'h2300_0000, 1'b0, -1, 2'b10, 1'b0);
      check("err_set", 64'(BRESP_ERR), 64'd1);
      pulse_start(32'h2400_0000, 2'b00);
      check("err_busy_start", 64'(BRESP_ERR), 64'd1);
      run_burst(32'h2300_0080, 1'b0, -1, 2'b00, 1'b0);
      check("err_sticky", 64'(BRESP_ERR), 64'd1);
      jump_to(24574, 32'h2300_0000);
      run_burst(32'h2300_0000 + 32'(24574 * 128), 1'b0, -1, 2'b00, 1'b0);
      run_burst(32'h2300_0000 + 32'(24575 * 128), 1'b0, 3, 2'b00, 1'b1);
      STOP = 1'b0;
      check_frame_end("xga");
      check("err_after_frame", 64'(BRESP_ERR), 64'd1);

      // A new START clears the error flag; reset mid-DATA then abandons it.
      pulse_start(32'h2400_0000, 2'b00);
      check("err_cleared", 64'(BRESP_ERR), 64'd0);
      @(negedge ACLK);
      check("rst_aw", 64'(M_AXI_AWVALID), 64'd1);
      M_AXI_AWREADY = 1'b1;
      @(negedge ACLK);
      M_AXI_AWREADY = 1'b0;
      M_AXI_WREADY  = 1'b1;
      repeat (5) begin
         @(negedge ACLK);
         exp_idx++;
      end
      ARESETN      = 1'b0;
      M_AXI_WREADY = 1'b0;
      #1;
      check_idle_outputs("mid_reset");
      @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      check("post_rst_busy", 64'(BUSY), 64'd0);
      pulse_start(32'h3000_007F, 2'b00);
      run_burst(32'h3000_0000, 1'b0, -1, 2'b00, 1'b0);
      run_burst(32'h3000_0080, 1'b1, -1, 2'b00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
